ysyx_25030093_ifu_prefetch: RTL and testbench
=============================================

// Module: ysyx_25030093_ifu_prefetch
// PURPOSE
//  Parametrised instruction fetch unit with a DEPTH-entry prefetch queue. Fetches sequentially
//  (pc+4) over SimpleBus ahead of IDU consumption and redirects/flushes on branch/exception.
//  Sits between the PC/redirect source (EXU/WBU) and IDU; one bus request outstanding at a time.
// PARAMETERS
//  XLEN      32            address/instruction width
//  DEPTH     4             prefetch queue entries; power of 2, >=2
//  RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//  clock          in   1     clock
//  reset          in   1     reset, synchronous, active-high
//  redirect_valid in   1     flush queue, restart fetch at redirect_pc
//  redirect_pc    in   XLEN  new fetch address; bits[1:0] must be 0
//  out_valid      out  1     queue head valid toward IDU
//  out_ready      in   1     IDU accepts head
//  out_inst       out  XLEN  head instruction
//  out_pc         out  XLEN  head instruction address
//  out_err        out  1     head fetch returned bus error
//  IFU_addr       out  XLEN  SimpleBus request address
//  IFU_reqValid   out  1     SimpleBus request; one-cycle pulse
//  IFU_rdata      in   XLEN  SimpleBus read data
//  IFU_respValid  in   1     SimpleBus response strobe
//  IFU_respErr    in   1     SimpleBus error, qualified by IFU_respValid
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, out_valid=0, out_inst/out_pc=0, out_err=0,
//   IFU_reqValid=0, IFU_addr=0, state IDLE, discard=0, halted=0.
//  FSM: IDLE -> REQ when credit && !halted && !redirect_valid; REQ (IFU_reqValid=1 exactly
//   1 cycle, IFU_addr=fetch_pc, fetch_pc+=4) -> WAIT; WAIT -> IDLE on IFU_respValid.
//  Credit: count + (state!=IDLE) < DEPTH; queue never overflows, so no push-at-full case.
//  Response in WAIT: push {fetch pc, IFU_rdata, IFU_respErr} unless discard; clear discard.
//  Latency: first IFU_reqValid in first cycle after reset deasserts; response at edge N ->
//   out_valid=1 from cycle N+1. Back-to-back 1-cycle responses sustain 1 fetch / 3 cycles.
//  Queue: out_* = head entry; pop on out_valid&&out_ready; push+pop same cycle keeps count;
//   pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  Redirect (highest priority): queue cleared, out_valid=0 next cycle, fetch_pc<=redirect_pc,
//   halted cleared. If state is REQ/WAIT, discard<=1 and the pending response is dropped;
//   a response in the same cycle as redirect is dropped. New request issues only after the
//   FSM returns to IDLE; no bus request is ever aborted.
//  Error: entry with err=1 is queued; halted<=1, no further requests until redirect.
//  pc arithmetic wraps modulo 2^XLEN (0xFFFF_FFFC+4 -> 0).
//  IFU_respValid outside WAIT is ignored. Reset mid-transaction returns all state to reset
//   values; the bus slave shares reset.
// STRUCTURE
//  Package ysyx_25030093_ifu_pkg: FSM encodings (IDLE/REQ/WAIT), INST_BYTES=4, entry struct
//   {pc, inst, err}.
//  Sub-module ysyx_25030093_ifu_fifo: sync FIFO (WIDTH, DEPTH) with push/pop/flush/count,
//   registered head output; top holds FSM, fetch_pc, credit, discard/halted.
// TESTING
//  1 reset release, slave 1-cycle latency, out_ready=1 -> addrs 0x80000000,04,08 in order;
//    out_pc/out_inst match memory.
//  2 out_ready=0, DEPTH=4 -> exactly 4 requests, then IFU_reqValid stays 0; raise out_ready
//    -> fetch resumes at 0x80000010.
//  3 redirect_valid to 0x80000100 while WAIT -> stale response dropped; next out_pc=0x80000100.
//  4 redirect same cycle as IFU_respValid and as pop -> queue empty, no stale entry appears.
//  5 IFU_respErr=1 at 0x8000000C -> entry out_err=1, no further requests until redirect.
//  6 redirect_pc=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x00000000; reset mid-WAIT -> restart
//    at RESET_PC.

Source files
------------

// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared types for the prefetching instruction fetch unit.
// FSM encodings and the queued fetch entry layout.
package ysyx_25030093_ifu_pkg;

  localparam int IFU_XLEN   = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [IFU_XLEN-1:0] inst;
    logic                err;
  } ifu_entry_t;

endpackage

// File: rtl/ysyx_25030093_ifu_fifo.sv
// Synchronous FIFO with flush; head entry read straight from storage regs.
// Caller guarantees no push while full.
module ysyx_25030093_ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;

  assign w_pop = pop && (r_cnt != '0);
  assign dout  = r_mem[r_rp];
  assign count = r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      r_cnt <= r_cnt + CW'(push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/ysyx_25030093_ifu_prefetch.sv
// Sequential fetch engine feeding a prefetch queue toward IDU.
// One SimpleBus request in flight; redirects flush and drop stale data.
module ysyx_25030093_ifu_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  output logic [XLEN-1:0] IFU_addr,
  output logic            IFU_reqValid,
  input  logic [XLEN-1:0] IFU_rdata,
  input  logic            IFU_respValid,
  input  logic            IFU_respErr
);

  import ysyx_25030093_ifu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_e      r_state;
  ifu_state_e      w_next;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_addr;
  logic            r_discard;
  logic            r_halted;

  logic [CW-1:0]   w_count;
  logic            w_credit;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  ifu_entry_t      w_in;
  ifu_entry_t      w_head;

  assign w_credit =
    (int'(w_count) + int'(r_state != S_IDLE)) < DEPTH;
  assign w_resp  = (r_state == S_WAIT) && IFU_respValid;
  assign w_push  = w_resp && !r_discard && !redirect_valid;
  assign w_pop   = out_valid && out_ready;
  assign w_issue = (r_state == S_IDLE) && (w_next == S_REQ);

  assign w_in = '{pc: r_addr, inst: IFU_rdata, err: IFU_respErr};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_credit && !r_halted && !redirect_valid) begin
          w_next = S_REQ;
        end
      end
      S_REQ:  w_next = S_WAIT;
      S_WAIT: begin
        if (IFU_respValid) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= '0;
      r_discard  <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(INST_BYTES);
      end
      if (w_issue) begin
        r_addr <= r_fetch_pc;
      end
      // A response landing now consumes the in-flight request itself.
      if (w_resp) begin
        r_discard <= 1'b0;
      end else if (redirect_valid && (r_state != S_IDLE)) begin
        r_discard <= 1'b1;
      end
      if (redirect_valid) begin
        r_halted <= 1'b0;
      end else if (w_push && IFU_respErr) begin
        r_halted <= 1'b1;
      end
    end
  end

  ysyx_25030093_ifu_fifo #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_in),
    .dout  (w_head),
    .count (w_count)
  );

  assign out_valid    = (w_count != '0);
  assign out_pc       = w_head.pc;
  assign out_inst     = w_head.inst;
  assign out_err      = w_head.err;
  assign IFU_reqValid = (r_state == S_REQ);
  assign IFU_addr     = r_addr;

endmodule

// File: tb/tb_ysyx_25030093_ifu_prefetch.sv
// Bench for the prefetching IFU: bus slave model plus expected-entry
// scoreboard consumed on every IDU handshake.
module tb_ysyx_25030093_ifu_prefetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_err;
  logic [31:0] IFU_addr;
  logic        IFU_reqValid;
  logic [31:0] IFU_rdata = '0;
  logic        IFU_respValid = 1'b0;
  logic        IFU_respErr = 1'b0;

  ysyx_25030093_ifu_prefetch dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_err        (out_err),
    .IFU_addr       (IFU_addr),
    .IFU_reqValid   (IFU_reqValid),
    .IFU_rdata      (IFU_rdata),
    .IFU_respValid  (IFU_respValid),
    .IFU_respErr    (IFU_respErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  logic [31:0] err_addr = 32'h1;
  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  int          req_cnt = 0;
  bit          s_pend = 0;
  int          s_cnt = 0;
  logic [31:0] s_addr = '0;
  exp_t        mon_e;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic e);
    exp_t r;
    r.pc = a;
    r.inst = inst_of(a);
    r.err = e;
    return r;
  endfunction

  // SimpleBus slave: answers lat cycles after seeing the request.
  always @(posedge clock) begin
    #1;
    IFU_respValid = 1'b0;
    IFU_respErr = 1'b0;
    if (reset) begin
      s_pend = 0;
    end else begin
      if (s_pend) begin
        if (s_cnt == 0) begin
          IFU_respValid = 1'b1;
          IFU_rdata = inst_of(s_addr);
          IFU_respErr = (s_addr == err_addr);
          s_pend = 0;
        end else begin
          s_cnt--;
        end
      end
      if (IFU_reqValid) begin
        s_pend = 1;
        s_addr = IFU_addr;
        s_cnt = lat - 1;
        req_q.push_back(IFU_addr);
        req_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected pc=%h inst=%h err=%b required no entry",
                 out_pc, out_inst, out_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_pc, out_inst, out_err} !==
            {mon_e.pc, mon_e.inst, mon_e.err}) begin
          failures++;
          $display("FAIL pop_entry got pc=%h inst=%h err=%b required pc=%h inst=%h err=%b",
                   out_pc, out_inst, out_err, mon_e.pc, mon_e.inst, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    lat = 1;
    err_addr = 32'h1;
    repeat (3) tick();
    exp_q.delete();
    req_q.delete();
    req_cnt = 0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks += 6;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_valid got %b required 0", out_valid);
    end
    if (IFU_reqValid !== 1'b0) begin
      failures++;
      $display("FAIL rst_reqValid got %b required 0", IFU_reqValid);
    end
    if (IFU_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_addr got %h required 0", IFU_addr);
    end
    if (out_pc !== 32'h0) begin
      failures++;
      $display("FAIL rst_out_pc got %h required 0", out_pc);
    end
    if (out_inst !== 32'h0) begin
      failures++;
      $display("FAIL rst_out_inst got %h required 0", out_inst);
    end
    if (out_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_out_err got %b required 0", out_err);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(32'h8000_0000 + 32'(4 * i), 1'b0));
    end
    out_ready = 1'b1;
    reset = 1'b0;
    tick();
    @(negedge clock);
    checks++;
    if (IFU_reqValid !== 1'b1 || IFU_addr !== 32'h8000_0000) begin
      failures++;
      $display("FAIL seq_first_req got v=%b a=%h required v=1 a=80000000",
               IFU_reqValid, IFU_addr);
    end
    drain(60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL seq_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_q[i] !== 32'h8000_0000 + 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_addr%0d got %h required %h",
                 i, req_q[i], 32'h8000_0000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    reset = 1'b0;
    repeat (40) tick();
    checks += 3;
    if (req_cnt != 4) begin
      failures++;
      $display("FAIL bp_req_count got %0d required 4", req_cnt);
    end
    if (IFU_reqValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_req_idle got %b required 0", IFU_reqValid);
    end
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_out_valid got %b required 1", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk(32'h8000_0000 + 32'(4 * i), 1'b0));
    end
    out_ready = 1'b1;
    drain(100, ok);
    checks += 2;
    if (!ok) begin
      failures++;
      $display("FAIL bp_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (req_q[4] !== 32'h8000_0010) begin
      failures++;
      $display("FAIL bp_resume_addr got %h required 80000010", req_q[4]);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    lat = 3;
    reset = 1'b0;
    for (int i = 0; i < 20 && req_cnt == 0; i++) tick();
    checks++;
    if (req_cnt != 1) begin
      failures++;
      $display("FAIL rw_first_req got %0d required 1", req_cnt);
    end
    tick();
    redirect_pc = 32'h8000_0100;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rw_flush got %b required 0", out_valid);
    end
    exp_q.push_back(mk(32'h8000_0100, 1'b0));
    exp_q.push_back(mk(32'h8000_0104, 1'b0));
    tick();
    out_ready = 1'b1;
    drain(100, ok);
    checks += 2;
    if (!ok) begin
      failures++;
      $display("FAIL rw_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (req_q[1] !== 32'h8000_0100) begin
      failures++;
      $display("FAIL rw_new_addr got %h required 80000100", req_q[1]);
    end
  endtask

  task automatic test_redirect_resp_pop();
    bit ok;
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (IFU_respValid && req_cnt == 3) break;
      tick();
    end
    checks++;
    if (!(IFU_respValid && req_cnt == 3)) begin
      failures++;
      $display("FAIL rp_setup got resp=%b reqs=%0d required 1/3",
               IFU_respValid, req_cnt);
    end
    exp_q.push_back(mk(32'h8000_0000, 1'b0));
    redirect_pc = 32'h8000_0200;
    redirect_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    checks += 2;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rp_flush got %b required 0", out_valid);
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rp_pop_seen left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    exp_q.push_back(mk(32'h8000_0200, 1'b0));
    tick();
    out_ready = 1'b1;
    drain(60, ok);
    checks += 2;
    if (!ok) begin
      failures++;
      $display("FAIL rp_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (req_q[3] !== 32'h8000_0200) begin
      failures++;
      $display("FAIL rp_new_addr got %h required 80000200", req_q[3]);
    end
  endtask

  task automatic test_error();
    bit ok;
    do_reset();
    err_addr = 32'h8000_000C;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(32'h8000_0000 + 32'(4 * i), i == 3));
    end
    out_ready = 1'b1;
    reset = 1'b0;
    drain(80, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL err_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (30) tick();
    checks += 2;
    if (req_cnt != 4) begin
      failures++;
      $display("FAIL err_halt_reqs got %0d required 4", req_cnt);
    end
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_halt_valid got %b required 0", out_valid);
    end
    exp_q.push_back(mk(32'h8000_0300, 1'b0));
    redirect_pc = 32'h8000_0300;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    drain(60, ok);
    checks += 2;
    if (!ok) begin
      failures++;
      $display("FAIL err_resume left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (req_q[4] !== 32'h8000_0300) begin
      failures++;
      $display("FAIL err_resume_addr got %h required 80000300", req_q[4]);
    end
  endtask

  task automatic test_wrap_and_reset();
    bit ok;
    do_reset();
    redirect_pc = 32'hFFFF_FFFC;
    redirect_valid = 1'b1;
    reset = 1'b0;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(mk(32'hFFFF_FFFC, 1'b0));
    exp_q.push_back(mk(32'h0000_0000, 1'b0));
    out_ready = 1'b1;
    drain(60, ok);
    checks += 3;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (req_q[0] !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_addr0 got %h required fffffffc", req_q[0]);
    end
    if (req_q[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_addr1 got %h required 00000000", req_q[1]);
    end
    do_reset();
    lat = 3;
    reset = 1'b0;
    for (int i = 0; i < 20 && !(s_pend && s_cnt == 2); i++) tick();
    tick();
    checks++;
    if (!(s_pend && IFU_reqValid === 1'b0)) begin
      failures++;
      $display("FAIL mr_wait_state got pend=%b req=%b required 1/0",
               s_pend, IFU_reqValid);
    end
    do_reset();
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || IFU_reqValid !== 1'b0) begin
      failures++;
      $display("FAIL mr_reset got v=%b req=%b required 0/0",
               out_valid, IFU_reqValid);
    end
    exp_q.push_back(mk(32'h8000_0000, 1'b0));
    tick();
    out_ready = 1'b1;
    reset = 1'b0;
    drain(60, ok);
    checks += 2;
    if (!ok) begin
      failures++;
      $display("FAIL mr_drain left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    if (req_q[0] !== 32'h8000_0000) begin
      failures++;
      $display("FAIL mr_restart_addr got %h required 80000000", req_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp_pop();
    test_error();
    test_wrap_and_reset();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
